// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline control blocks: hazard FSM states and register-index constants.
package pipeline_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        HZ_RUN,
        HZ_MD_BUSY
    } hz_state_t;

endpackage

// File: rtl/hazard_lu_detect.sv
// Combinational load-use detector: flags an ID-stage source that matches a load's destination in EX.
module hazard_lu_detect #(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    output logic                  load_use
);
    import pipeline_pkg::*;

    // x0 is hard-wired to zero, so a load targeting it can never create a real dependency.
    always_comb begin
        load_use = ex_mem_read
                && (ex_rd != REG_ADDR_W'(REG_ZERO))
                && ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, branch flushes, mul/div freeze.
// Optional performance counters are built only when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int MD_LATENCY = 4,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  ex_md_start,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_write,
    output logic                  id_ex_flush,
    output logic                  ex_mem_flush,
    output logic                  md_busy,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_flush_cnt
);
    import pipeline_pkg::*;

    localparam int CNT_W = $clog2(MD_LATENCY) + 1;
    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'((MD_LATENCY > 1) ? MD_LATENCY - 2 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    hz_state_t        state;
    logic [CNT_W-1:0] md_cnt;
    logic             lu;

    hazard_lu_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_lu_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_use    (lu)
    );

    // The entry cycle is itself a freeze, so MD_BUSY only lasts MD_LATENCY-2 cycles
    // and a two-cycle op never leaves RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= HZ_RUN;
            md_cnt <= '0;
        end else begin
            case (state)
                HZ_RUN: begin
                    if (!ex_branch_taken && ex_md_start && (MD_LOAD != '0)) begin
                        state  <= HZ_MD_BUSY;
                        md_cnt <= MD_LOAD;
                    end
                end
                HZ_MD_BUSY: begin
                    md_cnt <= md_cnt - CNT_ONE;
                    if (md_cnt == CNT_ONE) begin
                        state <= HZ_RUN;
                    end
                end
                default: state <= HZ_RUN;
            endcase
        end
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        md_busy      = 1'b0;
        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (state == HZ_MD_BUSY) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_flush = 1'b1;
            md_busy      = 1'b1;
        end else if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
        end else if (ex_md_start && (MD_LATENCY > 1)) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_flush = 1'b1;
        end else if (lu) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_flush  = 1'b1;
        end
    end

    a_no_branch_with_md: assert property (@(posedge clk) disable iff (reset)
        !(ex_branch_taken && ex_md_start));

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_write && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (if_id_flush && (flush_q != 32'hFFFF_FFFF)) begin
                flush_q <= flush_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = stall_q;
    assign perf_flush_cnt = flush_q;
`else
    assign perf_stall_cnt = 32'h0;
    assign perf_flush_cnt = 32'h0;
`endif

endmodule
